// File: rtl/sr_pkg.sv
// Shared constants and next-state rule for the SR flip-flop bank.
// Each cell uses next_q(); the top uses the mode bounds to check its parameters.
package sr_pkg;

  localparam int unsigned SR11_HOLD   = 0;
  localparam int unsigned SR11_SET    = 1;
  localparam int unsigned SR11_RST    = 2;
  localparam int unsigned SR11_TOGGLE = 3;
  localparam int unsigned SR11_MAX    = SR11_TOGGLE;

  // Next state of one SR cell; mode resolves the s=r=1 case.
  function automatic logic next_q(
    input logic        q,
    input logic        s,
    input logic        r,
    input int unsigned mode
  );
    logic w_next;
    w_next = q;
    unique case ({s, r})
      2'b00: w_next = q;
      2'b01: w_next = 1'b0;
      2'b10: w_next = 1'b1;
      2'b11: begin
        unique case (mode)
          SR11_SET:    w_next = 1'b1;
          SR11_RST:    w_next = 1'b0;
          SR11_TOGGLE: w_next = ~q;
          default:     w_next = q;
        endcase
      end
      default: w_next = q;
    endcase
    return w_next;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// Single clocked SR cell with asynchronous active-high reset.
// s/r are sampled only on the rising clk edge.
module sr_cell
  import sr_pkg::*;
#(
  parameter int unsigned SR11_MODE = SR11_HOLD,
  parameter int unsigned RST_VAL   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q
);

  localparam logic RST_BIT = (RST_VAL != 0);

  logic r_q;

  // The reset port is active-high despite its name; it is in the sensitivity
  // list so it takes effect without a clock edge.
  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: non-blocking assignment so every cell samples the pre-edge state.
    if (rst_n) begin
      r_q <= RST_BIT;
    end else begin
      r_q <= next_q(r_q, s, r, SR11_MODE);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent SR flip-flops sharing clock and reset.
// q_bar is the combinational complement of q, so both are never high together.
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned SR11_MODE = SR11_HOLD,
  parameter int unsigned RST_VAL   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  if (WIDTH < 1) begin : g_bad_width
    $error("sr_flip_flop: WIDTH must be at least 1");
  end
  if (SR11_MODE > SR11_MAX) begin : g_bad_mode
    $error("sr_flip_flop: SR11_MODE must be 0..3");
  end
  if (RST_VAL > 1) begin : g_bad_rst_val
    $error("sr_flip_flop: RST_VAL must be 0 or 1");
  end

  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .SR11_MODE (SR11_MODE),
      .RST_VAL   (RST_VAL)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (s[i]),
      .r     (r[i]),
      .q     (w_q[i])
    );
  end

  assign q     = w_q;
  assign q_bar = ~w_q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed plus randomized check of the SR flip-flop bank across all s=r=1 modes,
// both reset values and WIDTH 1/4, against a per-bit truth-table model.
module tb_sr_flip_flop;

  localparam int N_DUT = 5;

  logic       clk;
  logic       rst;
  logic [3:0] s;
  logic [3:0] r;

  logic [3:0] q0, q1, q2, q3, qb0, qb1, qb2, qb3;
  logic [0:0] q4, qb4;

  int vectors;
  int miscompares;

  // Model state and configuration for each instance.
  logic [3:0] m_q   [N_DUT];
  int         m_mode[N_DUT];
  logic       m_rst [N_DUT];
  logic [3:0] m_mask[N_DUT];

  sr_flip_flop #(.WIDTH(4), .SR11_MODE(0), .RST_VAL(0)) u_dut0 (
    .clk(clk), .rst_n(rst), .s(s), .r(r), .q(q0), .q_bar(qb0));
  sr_flip_flop #(.WIDTH(4), .SR11_MODE(1), .RST_VAL(0)) u_dut1 (
    .clk(clk), .rst_n(rst), .s(s), .r(r), .q(q1), .q_bar(qb1));
  sr_flip_flop #(.WIDTH(4), .SR11_MODE(2), .RST_VAL(0)) u_dut2 (
    .clk(clk), .rst_n(rst), .s(s), .r(r), .q(q2), .q_bar(qb2));
  sr_flip_flop #(.WIDTH(4), .SR11_MODE(3), .RST_VAL(0)) u_dut3 (
    .clk(clk), .rst_n(rst), .s(s), .r(r), .q(q3), .q_bar(qb3));
  sr_flip_flop #(.WIDTH(1), .SR11_MODE(0), .RST_VAL(1)) u_dut4 (
    .clk(clk), .rst_n(rst), .s(s[0:0]), .r(r[0:0]), .q(q4), .q_bar(qb4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truth table of an SR flip-flop, applied bit by bit.
  function automatic logic [3:0] model_next(input logic [3:0] q, input logic [3:0] sv,
                                            input logic [3:0] rv, input int mode);
    logic [3:0] n;
    for (int b = 0; b < 4; b++) begin
      if (sv[b] && !rv[b])      n[b] = 1'b1;
      else if (!sv[b] && rv[b]) n[b] = 1'b0;
      else if (!sv[b] && !rv[b]) n[b] = q[b];
      else if (mode == 1)       n[b] = 1'b1;
      else if (mode == 2)       n[b] = 1'b0;
      else if (mode == 3)       n[b] = !q[b];
      else                      n[b] = q[b];
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < N_DUT; d++) m_q[d] = {4{m_rst[d]}} & m_mask[d];
  endtask

  task automatic check_all(input string tag);
    logic [3:0] obs_q [N_DUT];
    logic [3:0] obs_qb[N_DUT];
    obs_q[0] = q0; obs_q[1] = q1; obs_q[2] = q2; obs_q[3] = q3; obs_q[4] = {3'b000, q4};
    obs_qb[0] = qb0; obs_qb[1] = qb1; obs_qb[2] = qb2; obs_qb[3] = qb3;
    obs_qb[4] = {3'b000, qb4};
    for (int d = 0; d < N_DUT; d++) begin
      vectors++;
      assert (obs_q[d] === m_q[d]) else begin
        miscompares++;
        $error("FAIL %s dut%0d q observed=%b expected=%b", tag, d, obs_q[d], m_q[d]);
      end
      vectors++;
      assert (obs_qb[d] === (~m_q[d] & m_mask[d])) else begin
        miscompares++;
        $error("FAIL %s dut%0d q_bar observed=%b expected=%b", tag, d, obs_qb[d],
               ~m_q[d] & m_mask[d]);
      end
    end
  endtask

  // One rising edge: model follows the sampled inputs, outputs are checked 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else for (int d = 0; d < N_DUT; d++)
      m_q[d] = model_next(m_q[d], s, r, m_mode[d]) & m_mask[d];
    #1;
    check_all(tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int d = 0; d < 4; d++) begin
      m_mode[d] = d; m_rst[d] = 1'b0; m_mask[d] = 4'hF;
    end
    m_mode[4] = 0; m_rst[4] = 1'b1; m_mask[4] = 4'h1;

    // Reset held from time zero while clocking with s asserted.
    rst = 1'b1; s = 4'hF; r = 4'h0;
    model_reset();
    #1 check_all("reset_t0");
    for (int i = 0; i < 3; i++) step("reset_held");

    // Release between edges, then hold for three edges.
    rst = 1'b0; s = 4'h0; r = 4'h0;
    for (int i = 0; i < 3; i++) step("hold_after_release");

    // Reset request, then set, then drop s and hold.
    r = 4'hF; step("reset_req");
    s = 4'hF; r = 4'h0; step("set_req");
    s = 4'h0; step("hold_set");

    // Asynchronous reset between edges.
    rst = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    rst = 1'b0;

    // s=r=1 with every bit at 1, for two edges to see the toggle mode flip back.
    s = 4'hF; r = 4'h0; step("preset_ones");
    r = 4'hF; step("sr11_first");
    step("sr11_second");

    // Mixed per-bit pattern from all-zero state.
    rst = 1'b1; #1 model_reset(); rst = 1'b0;
    s = 4'b0000; r = 4'b0000; step("clear");
    s = 4'b0101; r = 4'b0011; step("mixed_bits");

    // A pulse on s that starts and ends between edges must be ignored.
    s = 4'h0; r = 4'h0;
    #2 s = 4'hF;
    #2 s = 4'h0;
    step("glitch_ignored");

    // Random inputs with occasional mid-cycle reset.
    for (int i = 0; i < 200; i++) begin
      s = 4'($urandom);
      r = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        #1 model_reset();
        check_all("rand_async_reset");
        rst = ($urandom_range(0, 1) == 1);
      end
      step("random");
      if (rst) begin
        #1 rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
